ariane_regfile_sec: RTL and testbench
=====================================

# ariane_regfile_sec

Parametrised flip-flop register file for the CVA6 integer/FP datapath. It succeeds the fixed 32-entry file with generalised depth, width and port counts, optional write-to-read bypass, and per-entry dirty tracking. It replaces the raw combinational plaintext tap with a handshaked single-outstanding tap port for the security engine. It also provides a sequential secure-wipe engine that zeroes the file one entry per cycle.

## Interface
- DATA_WIDTH, 32, bits per entry
- ADDR_WIDTH, 5, address bits; NUM_WORDS = 2**ADDR_WIDTH
- NR_READ_PORTS, 2, combinational read ports
- NR_WRITE_PORTS, 2, write (commit) ports; higher index has priority
- ZERO_REG_ZERO, 0, 1 = entry 0 is hardwired to zero
- BYPASS, 0, 1 = same-cycle write data forwarded to reads

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- raddr_i  in  NR_READ_PORTS x ADDR_WIDTH  read addresses
- rdata_o  out  NR_READ_PORTS x DATA_WIDTH  read data
- waddr_i  in  NR_WRITE_PORTS x ADDR_WIDTH  write addresses
- wdata_i  in  NR_WRITE_PORTS x DATA_WIDTH  write data
- we_i  in  NR_WRITE_PORTS  write enables
- tap_req_valid_i  in  1  tap request valid
- tap_req_ready_o  out  1  tap request accepted
- tap_addr_i  in  ADDR_WIDTH  entry to capture
- tap_rsp_valid_o  out  1  captured word valid
- tap_rsp_ready_i  in  1  consumer accepts word
- tap_rsp_data_o  out  DATA_WIDTH  captured word
- tap_rsp_addr_o  out  ADDR_WIDTH  address of captured word
- wipe_i  in  1  start secure wipe (level sampled in IDLE)
- wipe_busy_o  out  1  wipe in progress
- wipe_done_o  out  1  one-cycle pulse after the final entry is cleared
- dirty_o  out  NUM_WORDS  per-entry written-since-wipe flags

## Operation
- Reset values: all entries 0, dirty_o 0, tap_rsp_valid_o 0, tap_rsp_data_o 0, tap_rsp_addr_o 0, wipe_busy_o 0, wipe_done_o 0, FSM IDLE, wipe pointer 0.
- Writes: on each edge, every port with we_i=1 writes. If several ports target one address, the highest index wins. Each write sets dirty[addr].
- With ZERO_REG_ZERO=1:
  - writes to address 0 are dropped and dirty[0] stays 0;
  - reads of address 0 return 0.
- Reads: rdata_o[i] = mem[raddr_i[i]], combinational.
- BYPASS=1: if any port writes raddr_i[i] this cycle, rdata_o[i] returns the winning wdata. Address 0 is excluded when ZERO_REG_ZERO=1.
- Tap port (one outstanding):
  - tap_req_ready_o = !wipe_busy_o && (!tap_rsp_valid_o || tap_rsp_ready_i).
  - A request is accepted on an edge where valid and ready are both high. At that edge the response registers load mem[tap_addr_i] and tap_addr_i, and tap_rsp_valid_o is set.
  - The captured value is the pre-edge contents: no bypass, so a same-edge write is not seen.
  - tap_rsp_valid_o clears on an edge where tap_rsp_ready_i=1 and no new request is accepted.
  - Response data is held stable while valid && !ready.
- Wipe FSM, states IDLE and WIPE:
  - IDLE -> WIPE when wipe_i=1 on an edge; the pointer is set to 0.
  - In WIPE, each edge clears mem[ptr] and dirty[ptr], then increments ptr.
  - The edge that clears entry NUM_WORDS-1 returns the FSM to IDLE and sets wipe_done_o for exactly one cycle.
  - wipe_i is ignored while in WIPE.
- While wipe_busy_o=1:
  - all write ports are ignored and dirty is not set;
  - tap_req_ready_o=0;
  - a pending tap response still drains normally;
  - reads continue and return the current (partly wiped) contents.
- Reset asserted mid-wipe: immediate return to reset values, with no wipe_done_o pulse.

## Timing
- Read latency 0 cycles (combinational). Write visible on rdata_o the cycle after the edge, or the same cycle with BYPASS=1.
- Tap: request accepted at edge k; response valid from cycle k+1. Back-to-back throughput is 1 per cycle when tap_rsp_ready_i is held high.
- Wipe:
  - wipe_i sampled at edge k;
  - wipe_busy_o is high for cycles k+1 .. k+NUM_WORDS;
  - wipe_done_o is high in cycle k+NUM_WORDS+1, when busy is already 0;
  - a new wipe may start at edge k+NUM_WORDS+1.
- All outputs other than rdata_o and tap_req_ready_o are direct flop outputs.

## Test plan
- Write conflict: ports 0 and 1 both write addr 5 (0xAAAA_0000, 0x5555_1111) -> mem[5]=0x5555_1111; dirty_o[5]=1; other dirty bits 0.
- Zero register and bypass (ZERO_REG_ZERO=1, BYPASS=1):
  - write 0xDEAD_BEEF to addr 0 -> rdata 0, dirty[0]=0;
  - write 0x1234 to addr 7 while reading addr 7 -> rdata_o=0x1234 in the same cycle.
- Tap backpressure: mem[3]=0xCAFE. Request addr 3 with tap_rsp_ready_i=0 for 4 cycles -> rsp valid, data 0xCAFE, addr 3 held stable, tap_req_ready_o=0. Raise ready -> a second request is accepted on the same edge.
- Tap same-edge write: request addr 9 (old value 0x1) on the edge port 0 writes 0x2 -> tap_rsp_data_o=0x1; the next read of addr 9 returns 0x2.
- Full wipe (ADDR_WIDTH=5): fill all entries. Pulse wipe_i while writing through port 0 mid-wipe ->
  - busy high for exactly 32 cycles;
  - the write is ignored;
  - done pulses once, 33 cycles after the start edge;
  - all entries 0 and dirty_o 0.
- Reset mid-wipe: assert rst_ni low at wipe cycle 10 -> busy 0 immediately; no done pulse; all outputs at their reset values.

Source files
------------

// File: rtl/ariane_regfile_sec.sv
`default_nettype none
// ============================================================================
// Module   : ariane_regfile_sec
// Purpose  : Parametrised flop register file with optional bypass, dirty
//            tracking, a handshaked single-outstanding tap port and a
//            sequential secure-wipe engine.
// Revision : 1.0 - initial release
// ============================================================================
module ariane_regfile_sec #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned NR_READ_PORTS  = 2,
    parameter int unsigned NR_WRITE_PORTS = 2,
    parameter int unsigned ZERO_REG_ZERO  = 0,
    parameter int unsigned BYPASS         = 0,
    localparam int unsigned NUM_WORDS     = 2**ADDR_WIDTH
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]     raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]    waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
    input  logic [NR_WRITE_PORTS-1:0]                    we_i,
    input  logic                                         tap_req_valid_i,
    output logic                                         tap_req_ready_o,
    input  logic [ADDR_WIDTH-1:0]                        tap_addr_i,
    output logic                                         tap_rsp_valid_o,
    input  logic                                         tap_rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                        tap_rsp_data_o,
    output logic [ADDR_WIDTH-1:0]                        tap_rsp_addr_o,
    input  logic                                         wipe_i,
    output logic                                         wipe_busy_o,
    output logic                                         wipe_done_o,
    output logic [NUM_WORDS-1:0]                         dirty_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WIPE = 1'b1
    } wipe_state_e;

    localparam logic [ADDR_WIDTH-1:0] c_last_ptr = ADDR_WIDTH'(NUM_WORDS - 1);

    wipe_state_e             r_state;
    wipe_state_e             w_state_next;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [ADDR_WIDTH-1:0]   w_ptr_next;
    logic                    r_wipe_done;
    logic                    w_wipe_done_next;
    logic                    w_busy;

    logic [DATA_WIDTH-1:0]   r_mem [NUM_WORDS];
    logic [NUM_WORDS-1:0]    r_dirty;

    logic [NUM_WORDS-1:0]    w_word_we;
    logic [DATA_WIDTH-1:0]   w_word_wdata [NUM_WORDS];
    logic [NUM_WORDS-1:0]    w_word_clr;

    logic                    r_tap_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_tap_rsp_data;
    logic [ADDR_WIDTH-1:0]   r_tap_rsp_addr;
    logic                    w_tap_req_ready;
    logic                    w_tap_accept;

    assign w_busy = (r_state == S_WIPE);

    // Per-entry write decode; ports scanned low to high so the highest index wins.
    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            w_word_we[w]    = 1'b0;
            w_word_wdata[w] = '0;
            for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                if (we_i[p] && (waddr_i[p] == ADDR_WIDTH'(w))) begin
                    w_word_we[w]    = 1'b1;
                    w_word_wdata[w] = wdata_i[p];
                end
            end
            if (w_busy || ((ZERO_REG_ZERO != 0) && (w == 0))) begin
                w_word_we[w] = 1'b0;
            end
            w_word_clr[w] = w_busy && (r_ptr == ADDR_WIDTH'(w));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                r_mem[w] <= '0;
            end
            r_dirty <= '0;
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                if (w_word_clr[w]) begin
                    r_mem[w]   <= '0;
                    r_dirty[w] <= 1'b0;
                end else if (w_word_we[w]) begin
                    r_mem[w]   <= w_word_wdata[w];
                    r_dirty[w] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < NR_READ_PORTS; i++) begin : g_rd
            logic [DATA_WIDTH-1:0] w_rd;
            always_comb begin
                w_rd = r_mem[raddr_i[i]];
                // w_word_we is already masked for entry 0 and during a wipe.
                if ((BYPASS != 0) && w_word_we[raddr_i[i]]) begin
                    w_rd = w_word_wdata[raddr_i[i]];
                end
                if ((ZERO_REG_ZERO != 0) && (raddr_i[i] == '0)) begin
                    w_rd = '0;
                end
            end
            assign rdata_o[i] = w_rd;
        end
    endgenerate

    // Tap captures pre-edge contents only; same-edge writes are not forwarded.
    assign w_tap_req_ready = !w_busy && (!r_tap_rsp_valid || tap_rsp_ready_i);
    assign w_tap_accept    = tap_req_valid_i && w_tap_req_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tap_rsp_valid <= 1'b0;
            r_tap_rsp_data  <= '0;
            r_tap_rsp_addr  <= '0;
        end else if (w_tap_accept) begin
            r_tap_rsp_valid <= 1'b1;
            r_tap_rsp_data  <= r_mem[tap_addr_i];
            r_tap_rsp_addr  <= tap_addr_i;
        end else if (tap_rsp_ready_i) begin
            r_tap_rsp_valid <= 1'b0;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_wipe_done_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wipe_i) begin
                    w_state_next = S_WIPE;
                    w_ptr_next   = '0;
                end
            end
            S_WIPE: begin
                w_ptr_next = r_ptr + ADDR_WIDTH'(1);
                if (r_ptr == c_last_ptr) begin
                    w_state_next     = S_IDLE;
                    w_wipe_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_wipe_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_wipe_done <= w_wipe_done_next;
        end
    end

    assign tap_req_ready_o = w_tap_req_ready;
    assign tap_rsp_valid_o = r_tap_rsp_valid;
    assign tap_rsp_data_o  = r_tap_rsp_data;
    assign tap_rsp_addr_o  = r_tap_rsp_addr;
    assign wipe_busy_o     = w_busy;
    assign wipe_done_o     = r_wipe_done;
    assign dirty_o         = r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_ariane_regfile_sec.sv
`default_nettype none
// ============================================================================
// Module   : tb_ariane_regfile_sec
// Purpose  : Directed bench for ariane_regfile_sec (zero-reg/bypass instance
//            plus a default-parameter instance sharing the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ariane_regfile_sec;

    logic             clk;
    logic             rst_n;
    logic [1:0][4:0]  raddr;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0]       we;
    logic             tap_req_valid;
    logic [4:0]       tap_addr;
    logic             tap_rsp_ready;
    logic             wipe;

    logic [1:0][31:0] rdata_d, rdata_p;
    logic             tap_req_ready_d, tap_req_ready_p;
    logic             tap_rsp_valid_d, tap_rsp_valid_p;
    logic [31:0]      tap_rsp_data_d, tap_rsp_data_p;
    logic [4:0]       tap_rsp_addr_d, tap_rsp_addr_p;
    logic             busy_d, busy_p, done_d, done_p;
    logic [31:0]      dirty_d, dirty_p;

    int n_checks = 0;
    int n_fail   = 0;

    ariane_regfile_sec #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NR_READ_PORTS(2), .NR_WRITE_PORTS(2),
        .ZERO_REG_ZERO(1), .BYPASS(1)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_d),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .tap_req_valid_i(tap_req_valid), .tap_req_ready_o(tap_req_ready_d),
        .tap_addr_i(tap_addr), .tap_rsp_valid_o(tap_rsp_valid_d),
        .tap_rsp_ready_i(tap_rsp_ready), .tap_rsp_data_o(tap_rsp_data_d),
        .tap_rsp_addr_o(tap_rsp_addr_d), .wipe_i(wipe), .wipe_busy_o(busy_d),
        .wipe_done_o(done_d), .dirty_o(dirty_d)
    );

    ariane_regfile_sec u_plain (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_p),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
        .tap_req_valid_i(tap_req_valid), .tap_req_ready_o(tap_req_ready_p),
        .tap_addr_i(tap_addr), .tap_rsp_valid_o(tap_rsp_valid_p),
        .tap_rsp_ready_i(tap_rsp_ready), .tap_rsp_data_o(tap_rsp_data_p),
        .tap_rsp_addr_o(tap_rsp_addr_p), .wipe_i(wipe), .wipe_busy_o(busy_p),
        .wipe_done_o(done_p), .dirty_o(dirty_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        raddr = '0;
        raddr[1] = 5'd17;
        #1;
        n_checks++; if (dirty_d !== 32'h0 || dirty_p !== 32'h0) begin n_fail++; $display("FAIL reset_dirty: got %h/%h expected 0", dirty_d, dirty_p); end
        n_checks++; if (tap_rsp_valid_d !== 1'b0 || tap_rsp_data_d !== 32'h0 || tap_rsp_addr_d !== 5'h0) begin n_fail++; $display("FAIL reset_tap: got v=%b d=%h a=%h expected 0", tap_rsp_valid_d, tap_rsp_data_d, tap_rsp_addr_d); end
        n_checks++; if (busy_d !== 1'b0 || done_d !== 1'b0) begin n_fail++; $display("FAIL reset_wipe: got busy=%b done=%b expected 0", busy_d, done_d); end
        n_checks++; if (rdata_d[1] !== 32'h0 || rdata_p[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0", rdata_d[1], rdata_p[0]); end
        n_checks++; if (tap_req_ready_d !== 1'b1) begin n_fail++; $display("FAIL reset_tap_ready: got %b expected 1", tap_req_ready_d); end
    endtask

    task automatic test_write_conflict();
        waddr[0] = 5'd5; wdata[0] = 32'hAAAA_0000;
        waddr[1] = 5'd5; wdata[1] = 32'h5555_1111;
        we = 2'b11;
        tick();
        we = 2'b00;
        raddr[0] = 5'd5;
        #1;
        n_checks++; if (rdata_d[0] !== 32'h5555_1111 || rdata_p[0] !== 32'h5555_1111) begin n_fail++; $display("FAIL conflict_data: got %h/%h expected 55551111", rdata_d[0], rdata_p[0]); end
        n_checks++; if (dirty_d !== 32'h0000_0020 || dirty_p !== 32'h0000_0020) begin n_fail++; $display("FAIL conflict_dirty: got %h/%h expected 00000020", dirty_d, dirty_p); end
    endtask

    task automatic test_zero_bypass();
        waddr[0] = 5'd0; wdata[0] = 32'hDEAD_BEEF; we = 2'b01;
        raddr[0] = 5'd0;
        #1;
        n_checks++; if (rdata_d[0] !== 32'h0 || rdata_p[0] !== 32'h0) begin n_fail++; $display("FAIL zero_same_cycle: got %h/%h expected 0", rdata_d[0], rdata_p[0]); end
        tick();
        we = 2'b00;
        #1;
        n_checks++; if (rdata_d[0] !== 32'h0) begin n_fail++; $display("FAIL zero_read: got %h expected 0", rdata_d[0]); end
        n_checks++; if (rdata_p[0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL plain_addr0: got %h expected deadbeef", rdata_p[0]); end
        n_checks++; if (dirty_d[0] !== 1'b0 || dirty_p[0] !== 1'b1) begin n_fail++; $display("FAIL zero_dirty: got %b/%b expected 0/1", dirty_d[0], dirty_p[0]); end
        waddr[0] = 5'd7; wdata[0] = 32'h0000_1234; we = 2'b01;
        raddr[1] = 5'd7;
        #1;
        n_checks++; if (rdata_d[1] !== 32'h0000_1234) begin n_fail++; $display("FAIL bypass: got %h expected 00001234", rdata_d[1]); end
        n_checks++; if (rdata_p[1] !== 32'h0) begin n_fail++; $display("FAIL no_bypass: got %h expected 0", rdata_p[1]); end
        tick();
        we = 2'b00;
        #1;
        n_checks++; if (rdata_p[1] !== 32'h0000_1234) begin n_fail++; $display("FAIL write_visible: got %h expected 00001234", rdata_p[1]); end
    endtask

    task automatic test_tap_backpressure();
        waddr[0] = 5'd3; wdata[0] = 32'h0000_CAFE; we = 2'b01;
        tick();
        we = 2'b00;
        tap_req_valid = 1'b1; tap_addr = 5'd3; tap_rsp_ready = 1'b0;
        #1;
        n_checks++; if (tap_req_ready_d !== 1'b1) begin n_fail++; $display("FAIL tap_idle_ready: got %b expected 1", tap_req_ready_d); end
        tick();
        tap_addr = 5'd5;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (tap_rsp_valid_d !== 1'b1 || tap_rsp_data_d !== 32'h0000_CAFE || tap_rsp_addr_d !== 5'd3) begin n_fail++; $display("FAIL tap_hold c%0d: got v=%b d=%h a=%h expected 1/cafe/3", c, tap_rsp_valid_d, tap_rsp_data_d, tap_rsp_addr_d); end
            n_checks++; if (tap_req_ready_d !== 1'b0) begin n_fail++; $display("FAIL tap_bp_ready c%0d: got %b expected 0", c, tap_req_ready_d); end
            tick();
        end
        tap_rsp_ready = 1'b1;
        #1;
        n_checks++; if (tap_req_ready_d !== 1'b1) begin n_fail++; $display("FAIL tap_drain_ready: got %b expected 1", tap_req_ready_d); end
        tick();
        tap_req_valid = 1'b0;
        n_checks++; if (tap_rsp_valid_d !== 1'b1 || tap_rsp_data_d !== 32'h5555_1111 || tap_rsp_addr_d !== 5'd5) begin n_fail++; $display("FAIL tap_second: got v=%b d=%h a=%h expected 1/55551111/5", tap_rsp_valid_d, tap_rsp_data_d, tap_rsp_addr_d); end
        tick();
        n_checks++; if (tap_rsp_valid_d !== 1'b0) begin n_fail++; $display("FAIL tap_clear: got %b expected 0", tap_rsp_valid_d); end
    endtask

    task automatic test_tap_same_edge();
        waddr[0] = 5'd9; wdata[0] = 32'h1; we = 2'b01;
        tick();
        wdata[0] = 32'h2;
        tap_req_valid = 1'b1; tap_addr = 5'd9;
        tick();
        we = 2'b00; tap_req_valid = 1'b0;
        n_checks++; if (tap_rsp_data_d !== 32'h1 || tap_rsp_data_p !== 32'h1 || tap_rsp_addr_d !== 5'd9) begin n_fail++; $display("FAIL tap_same_edge: got %h/%h a=%h expected 1/1/9", tap_rsp_data_d, tap_rsp_data_p, tap_rsp_addr_d); end
        raddr[0] = 5'd9;
        #1;
        n_checks++; if (rdata_d[0] !== 32'h2 || rdata_p[0] !== 32'h2) begin n_fail++; $display("FAIL same_edge_write: got %h/%h expected 2", rdata_d[0], rdata_p[0]); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  b_addr [3];
        logic [31:0] b_exp  [3];
        b_addr = '{5'd3, 5'd5, 5'd7};
        b_exp  = '{32'h0000_CAFE, 32'h5555_1111, 32'h0000_1234};
        tap_rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tap_req_valid = 1'b1; tap_addr = b_addr[i];
            #1;
            n_checks++; if (tap_req_ready_d !== 1'b1) begin n_fail++; $display("FAIL b2b_ready %0d: got %b expected 1", i, tap_req_ready_d); end
            tick();
            n_checks++; if (tap_rsp_valid_d !== 1'b1 || tap_rsp_data_d !== b_exp[i] || tap_rsp_addr_d !== b_addr[i]) begin n_fail++; $display("FAIL b2b_rsp %0d: got v=%b d=%h a=%h expected 1/%h/%h", i, tap_rsp_valid_d, tap_rsp_data_d, tap_rsp_addr_d, b_exp[i], b_addr[i]); end
        end
        tap_req_valid = 1'b0;
        tick();
        n_checks++; if (tap_rsp_valid_d !== 1'b0) begin n_fail++; $display("FAIL b2b_clear: got %b expected 0", tap_rsp_valid_d); end
    endtask

    task automatic test_full_wipe();
        int          busy_cnt;
        int          done_cnt;
        int          done_at;
        logic [31:0] acc_d;
        logic [31:0] acc_p;
        for (int a = 0; a < 16; a++) begin
            waddr[0] = 5'(a);      wdata[0] = 32'hA500_0000 | a;
            waddr[1] = 5'(a + 16); wdata[1] = 32'hA500_0000 | (a + 16);
            we = 2'b11;
            tick();
        end
        we = 2'b00;
        n_checks++; if (dirty_d !== 32'hFFFF_FFFE || dirty_p !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL fill_dirty: got %h/%h expected fffffffe/ffffffff", dirty_d, dirty_p); end
        wipe = 1'b1;
        tick();
        wipe = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int n = 1; n <= 36; n++) begin
            if (busy_d) busy_cnt++;
            if (done_d) begin done_cnt++; done_at = n; end
            if (n == 10) begin
                waddr[0] = 5'd2; wdata[0] = 32'h0000_0BAD; we = 2'b01;
                raddr[0] = 5'd20; raddr[1] = 5'd2;
                #1;
                n_checks++; if (rdata_d[0] !== 32'hA500_0014) begin n_fail++; $display("FAIL wipe_partial_read: got %h expected a5000014", rdata_d[0]); end
                n_checks++; if (rdata_d[1] !== 32'h0) begin n_fail++; $display("FAIL wipe_no_bypass: got %h expected 0", rdata_d[1]); end
                n_checks++; if (tap_req_ready_d !== 1'b0) begin n_fail++; $display("FAIL wipe_tap_ready: got %b expected 0", tap_req_ready_d); end
            end
            tick();
            we = 2'b00;
        end
        n_checks++; if (busy_cnt != 32) begin n_fail++; $display("FAIL wipe_busy_cycles: got %0d expected 32", busy_cnt); end
        n_checks++; if (done_cnt != 1 || done_at != 33) begin n_fail++; $display("FAIL wipe_done: got count=%0d at=%0d expected 1 at 33", done_cnt, done_at); end
        n_checks++; if (dirty_d !== 32'h0 || dirty_p !== 32'h0) begin n_fail++; $display("FAIL wipe_dirty: got %h/%h expected 0", dirty_d, dirty_p); end
        acc_d = '0; acc_p = '0;
        for (int a = 0; a < 32; a++) begin
            raddr[0] = 5'(a);
            #1;
            acc_d |= rdata_d[0];
            acc_p |= rdata_p[0];
        end
        n_checks++; if (acc_d !== 32'h0 || acc_p !== 32'h0) begin n_fail++; $display("FAIL wipe_contents: got or=%h/%h expected 0", acc_d, acc_p); end
    endtask

    task automatic test_reset_mid_wipe();
        int bad_cnt;
        waddr[0] = 5'd30; wdata[0] = 32'h30; we = 2'b01;
        tick();
        we = 2'b00;
        tap_req_valid = 1'b1; tap_addr = 5'd30; tap_rsp_ready = 1'b0;
        tick();
        tap_req_valid = 1'b0;
        wipe = 1'b1;
        tick();
        wipe = 1'b0;
        for (int n = 2; n <= 10; n++) tick();
        raddr[0] = 5'd30;
        #1;
        n_checks++; if (busy_d !== 1'b1 || rdata_d[0] !== 32'h30 || tap_rsp_valid_d !== 1'b1 || tap_rsp_data_d !== 32'h30) begin n_fail++; $display("FAIL pre_reset: got busy=%b rd=%h v=%b d=%h expected 1/30/1/30", busy_d, rdata_d[0], tap_rsp_valid_d, tap_rsp_data_d); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy_d !== 1'b0 || done_d !== 1'b0) begin n_fail++; $display("FAIL rst_wipe: got busy=%b done=%b expected 0", busy_d, done_d); end
        n_checks++; if (dirty_d !== 32'h0 || rdata_d[0] !== 32'h0) begin n_fail++; $display("FAIL rst_mem: got dirty=%h rd=%h expected 0", dirty_d, rdata_d[0]); end
        n_checks++; if (tap_rsp_valid_d !== 1'b0 || tap_rsp_data_d !== 32'h0 || tap_rsp_addr_d !== 5'h0) begin n_fail++; $display("FAIL rst_tap: got v=%b d=%h a=%h expected 0", tap_rsp_valid_d, tap_rsp_data_d, tap_rsp_addr_d); end
        bad_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done_d || busy_d) bad_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_d || busy_d) bad_cnt++;
        end
        n_checks++; if (bad_cnt != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d busy/done cycles expected 0", bad_cnt); end
    endtask

    initial begin
        rst_n = 1'b1;
        raddr = '0; waddr = '0; wdata = '0; we = '0;
        tap_req_valid = 1'b0; tap_addr = '0; tap_rsp_ready = 1'b0; wipe = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_write_conflict();
        test_zero_bypass();
        test_tap_backpressure();
        test_tap_same_edge();
        test_back_to_back();
        test_full_wipe();
        test_reset_mid_wipe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
